simplecpu2_ctrl: RTL and testbench

//  Multi-cycle control unit for simplecpu2. Sequences fetch/decode/execute across instmem, datamemory and

---
 rtl/simplecpu2_pkg.sv | 45 ++++
 rtl/simplecpu2_decoder.sv | 49 ++++
 rtl/simplecpu2_ctrl.sv | 141 ++++++++++++++
 tb/tb_simplecpu2_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simplecpu2_pkg.sv
// Shared types and default widths for the simplecpu2 control path.
//   opcode_t : 4-bit ISA opcodes (values 7..15 are illegal)
//   state_t  : multi-cycle sequencer states
//   alu_op_t : ALU function select driven to execunit
//   wb_sel_t : RegBank write-back source select
package simplecpu2_pkg;

    localparam int DEF_PC_W    = 10;
    localparam int DEF_DADDR_W = 8;
    localparam int DEF_IW      = 16;

    typedef enum logic [3:0] {
        OP_LOAD  = 4'd0,
        OP_STORE = 4'd1,
        OP_ADD   = 4'd2,
        OP_LOADC = 4'd3,
        OP_SUBS  = 4'd4,
        OP_JMPZ  = 4'd5,
        OP_ABS   = 4'd6
    } opcode_t;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_SUB  = 2'd1,
        ALU_ABS  = 2'd2,
        ALU_PASS = 2'd3
    } alu_op_t;

    // Encoding 2'd3 is never produced.
    typedef enum logic [1:0] {
        WB_ALU   = 2'd0,
        WB_MEM   = 2'd1,
        WB_CONST = 2'd2
    } wb_sel_t;

endpackage

// File: rtl/simplecpu2_decoder.sv
// Combinational opcode decoder for simplecpu2.
// Ports:
//   opcode      in   4  instruction bits [15:12]
//   is_legal    out  1  opcode is one of the seven defined instructions
//   is_mem      out  1  LOAD or STORE (goes through the MEM state)
//   alu_op      out  2  ALU function for this opcode (PASS when unused)
//   wb_sel      out  2  write-back source for this opcode
//   raddr_a_sel out  1  1 = RegBank port A reads rd (ir[11:8]), 0 = ra (ir[7:4])
module simplecpu2_decoder
    import simplecpu2_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_legal,
    output logic       is_mem,
    output alu_op_t    alu_op,
    output wb_sel_t    wb_sel,
    output logic       raddr_a_sel
);

    always_comb begin
        is_legal    = 1'b1;
        is_mem      = 1'b0;
        alu_op      = ALU_PASS;
        wb_sel      = WB_ALU;
        raddr_a_sel = 1'b0;
        case (opcode)
            OP_LOAD: begin
                is_mem = 1'b1;
                wb_sel = WB_MEM;
            end
            OP_STORE: begin
                // Store data comes from rd through port A.
                is_mem      = 1'b1;
                raddr_a_sel = 1'b1;
            end
            OP_ADD:   alu_op = ALU_ADD;
            OP_LOADC: wb_sel = WB_CONST;
            OP_SUBS:  alu_op = ALU_SUB;
            // JMPZ tests rd for zero via port A.
            OP_JMPZ:  raddr_a_sel = 1'b1;
            OP_ABS: begin
                alu_op      = ALU_ABS;
                raddr_a_sel = 1'b1;
            end
            default:  is_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/simplecpu2_ctrl.sv
// Multi-cycle control unit for simplecpu2: owns pc, ir and ir_pc and sequences
// FETCH -> DECODE -> EXEC/MEM(->WB) -> FETCH, or DECODE -> HALT on an illegal opcode.
// Ports:
//   clk, rst (sync, active-low), en (0 = freeze state, all strobes 0)
//   imem_rdata  : instmem data, valid the cycle after imem_ren
//   rf_a_zero   : RegBank port-A data is zero (sampled in EXEC for JMPZ)
//   pc, imem_ren                    : instruction fetch
//   dmem_ren, dmem_wen, dmem_addr   : data memory access
//   rf_raddr_a, rf_raddr_b, rf_wen, rf_waddr : RegBank control
//   alu_op, wb_sel, const_out       : execunit datapath selects
//   halt                            : sticky, set when an illegal opcode is decoded
module simplecpu2_ctrl
    import simplecpu2_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int DADDR_W = DEF_DADDR_W,
    parameter int IW      = DEF_IW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [IW-1:0]      imem_rdata,
    input  logic               rf_a_zero,
    output logic [PC_W-1:0]    pc,
    output logic               imem_ren,
    output logic               dmem_ren,
    output logic               dmem_wen,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [3:0]         rf_raddr_a,
    output logic [3:0]         rf_raddr_b,
    output logic               rf_wen,
    output logic [3:0]         rf_waddr,
    output logic [1:0]         alu_op,
    output logic [1:0]         wb_sel,
    output logic [7:0]         const_out,
    output logic               halt
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] ir_pc_q, ir_pc_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic            halt_q, halt_d;

    logic [3:0]      ir_op;
    logic [3:0]      dec_op;
    logic            dec_legal, dec_mem, dec_ra_sel;
    alu_op_t         dec_alu_op;
    wb_sel_t         dec_wb_sel;
    logic            run;
    logic [PC_W-1:0] jmp_off;

    assign ir_op = ir_q[15:12];

    // One decoder serves both uses: in DECODE it looks at the incoming word
    // to pick the next state, otherwise at the latched ir for EXEC/MEM/WB.
    assign dec_op = (state_q == DECODE) ? imem_rdata[15:12] : ir_op;

    simplecpu2_decoder u_decoder (
        .opcode      (dec_op),
        .is_legal    (dec_legal),
        .is_mem      (dec_mem),
        .alu_op      (dec_alu_op),
        .wb_sel      (dec_wb_sel),
        .raddr_a_sel (dec_ra_sel)
    );

    // Strobes are only live while running and out of reset, so a reset or a
    // stall in the middle of an instruction never issues a partial write.
    assign run = en & rst;

    assign jmp_off = {{(PC_W-8){ir_q[7]}}, ir_q[7:0]};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_pc_d = ir_pc_q;
        ir_d    = ir_q;
        halt_d  = halt_q;
        if (en) begin
            case (state_q)
                FETCH:  state_d = DECODE;
                DECODE: begin
                    ir_d    = imem_rdata;
                    ir_pc_d = pc_q;
                    pc_d    = pc_q + PC_W'(1);
                    if (!dec_legal) begin
                        state_d = HALT;
                        halt_d  = 1'b1;
                    end else if (dec_mem) begin
                        state_d = MEM;
                    end else begin
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    // Branch target is relative to the JMPZ's own address.
                    if (ir_op == OP_JMPZ && rf_a_zero) begin
                        pc_d = ir_pc_q + jmp_off;
                    end
                    state_d = FETCH;
                end
                MEM:     state_d = (ir_op == OP_LOAD) ? WB : FETCH;
                WB:      state_d = FETCH;
                HALT:    state_d = HALT;
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_pc_q <= '0;
            ir_q    <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_pc_q <= ir_pc_d;
            ir_q    <= ir_d;
            halt_q  <= halt_d;
        end
    end

    assign pc         = pc_q;
    assign halt       = halt_q;
    assign imem_ren   = run && (state_q == FETCH);
    assign dmem_ren   = run && (state_q == MEM) && (ir_op == OP_LOAD);
    assign dmem_wen   = run && (state_q == MEM) && (ir_op == OP_STORE);
    assign rf_wen     = run && (((state_q == EXEC) && (ir_op != OP_JMPZ)) || (state_q == WB));
    assign dmem_addr  = ir_q[DADDR_W-1:0];
    assign rf_raddr_a = dec_ra_sel ? ir_q[11:8] : ir_q[7:4];
    assign rf_raddr_b = ir_q[3:0];
    assign rf_waddr   = ir_q[11:8];
    assign alu_op     = dec_alu_op;
    assign wb_sel     = dec_wb_sel;
    assign const_out  = ir_q[7:0];

endmodule

// File: tb/tb_simplecpu2_ctrl.sv
module tb_simplecpu2_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] imem_rdata;
    logic        rf_a_zero;
    logic [9:0]  pc;
    logic        imem_ren, dmem_ren, dmem_wen, rf_wen, halt;
    logic [7:0]  dmem_addr, const_out;
    logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [1:0]  alu_op, wb_sel;

    simplecpu2_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .imem_rdata (imem_rdata),
        .rf_a_zero  (rf_a_zero),
        .pc         (pc),
        .imem_ren   (imem_ren),
        .dmem_ren   (dmem_ren),
        .dmem_wen   (dmem_wen),
        .dmem_addr  (dmem_addr),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .alu_op     (alu_op),
        .wb_sel     (wb_sel),
        .const_out  (const_out),
        .halt       (halt)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- instruction memory (environment) ----------------
    logic [15:0] imem [0:1023];

    always @(posedge clk) begin
        if (imem_ren) imem_rdata <= imem[pc];
    end

    // ---------------- reference model ----------------
    // One record per expected clock cycle (per enabled cycle) of an instruction.
    typedef struct packed {
        logic        zero;      // value driven on rf_a_zero during this cycle
        logic        halt;
        logic [9:0]  pc;
        logic        imem_ren;
        logic        dmem_ren;
        logic        dmem_wen;
        logic        rf_wen;
        logic        chk_ir;    // instruction fields visible on outputs
        logic [15:0] instr;
    } exp_t;

    localparam int W = $bits(exp_t);
    logic [W-1:0] exp_q[$];
    logic         zero_plan[$];
    int           m_pc;
    logic         m_halt;

    int n_checks;
    int n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic rz();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic exp_t mk(input logic z, input logic h, input logic [9:0] p,
                                input logic ir_, input logic dr, input logic dw,
                                input logic rw, input logic ck, input logic [15:0] w);
        exp_t r;
        r.zero = z; r.halt = h; r.pc = p;
        r.imem_ren = ir_; r.dmem_ren = dr; r.dmem_wen = dw; r.rf_wen = rw;
        r.chk_ir = ck; r.instr = w;
        return r;
    endfunction

    // Expand the instruction at m_pc into its cycle records and advance m_pc.
    task automatic gen_instr();
        logic [15:0] w;
        int          op, nxt, off;
        logic        z;
        w   = imem[m_pc];
        op  = int'(w[15:12]);
        nxt = (m_pc + 1) % 1024;
        exp_q.push_back(mk(rz(), 1'b0, 10'(m_pc), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, w));
        exp_q.push_back(mk(rz(), 1'b0, 10'(m_pc), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, w));
        if (op > 6) begin
            m_halt = 1'b1;
            m_pc   = nxt;
            return;
        end
        case (op)
            0: begin
                exp_q.push_back(mk(rz(), 1'b0, 10'(nxt), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, w));
                exp_q.push_back(mk(rz(), 1'b0, 10'(nxt), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, w));
            end
            1: exp_q.push_back(mk(rz(), 1'b0, 10'(nxt), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, w));
            5: begin
                z = (zero_plan.size() > 0) ? zero_plan.pop_front() : rz();
                exp_q.push_back(mk(z, 1'b0, 10'(nxt), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, w));
                if (z) begin
                    off = int'(w[7:0]);
                    if (off > 127) off = off - 256;
                    nxt = (m_pc + off) & 1023;
                end
            end
            default: exp_q.push_back(mk(rz(), 1'b0, 10'(nxt), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, w));
        endcase
        m_pc = nxt;
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic step(input logic en_v, input logic rst_v);
        exp_t c;
        int   op;
        logic [3:0] exp_ra;
        logic [1:0] exp_alu, exp_wb;
        @(negedge clk);
        if (rst_v && exp_q.size() == 0 && !m_halt) gen_instr();
        if (exp_q.size() > 0) c = exp_q[0];
        else c = mk(rz(), 1'b1, 10'(m_pc), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        en        = en_v;
        rst       = rst_v;
        rf_a_zero = c.zero;
        #1;
        if (!rst_v) begin
            check_eq("rst_imem_ren", 32'(imem_ren), 32'd0);
            check_eq("rst_dmem_ren", 32'(dmem_ren), 32'd0);
            check_eq("rst_dmem_wen", 32'(dmem_wen), 32'd0);
            check_eq("rst_rf_wen", 32'(rf_wen), 32'd0);
        end else begin
            check_eq("imem_ren", 32'(imem_ren), 32'(c.imem_ren & en_v));
            check_eq("dmem_ren", 32'(dmem_ren), 32'(c.dmem_ren & en_v));
            check_eq("dmem_wen", 32'(dmem_wen), 32'(c.dmem_wen & en_v));
            check_eq("rf_wen", 32'(rf_wen), 32'(c.rf_wen & en_v));
            check_eq("pc", 32'(pc), 32'(c.pc));
            check_eq("halt", 32'(halt), 32'(c.halt));
            if (c.chk_ir) begin
                op     = int'(c.instr[15:12]);
                exp_ra = (op == 1 || op == 5 || op == 6) ? c.instr[11:8] : c.instr[7:4];
                check_eq("dmem_addr", 32'(dmem_addr), 32'(c.instr[7:0]));
                check_eq("const_out", 32'(const_out), 32'(c.instr[7:0]));
                check_eq("rf_waddr", 32'(rf_waddr), 32'(c.instr[11:8]));
                check_eq("rf_raddr_a", 32'(rf_raddr_a), 32'(exp_ra));
                check_eq("rf_raddr_b", 32'(rf_raddr_b), 32'(c.instr[3:0]));
                if (c.rf_wen) begin
                    exp_wb = (op == 0) ? 2'd1 : (op == 3) ? 2'd2 : 2'd0;
                    check_eq("wb_sel", 32'(wb_sel), 32'(exp_wb));
                    if (op == 2 || op == 4 || op == 6) begin
                        exp_alu = (op == 2) ? 2'd0 : (op == 4) ? 2'd1 : 2'd2;
                        check_eq("alu_op", 32'(alu_op), 32'(exp_alu));
                    end
                end
            end
        end
        @(posedge clk);
        if (!rst_v) begin
            exp_q.delete();
            m_pc   = 0;
            m_halt = 1'b0;
        end else if (en_v && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
    endtask

    function automatic logic front_is_wen();
        exp_t c;
        if (exp_q.size() == 0) return 1'b0;
        c = exp_q[0];
        return c.dmem_wen;
    endfunction

    task automatic run_to_store(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (front_is_wen()) found = 1'b1;
            else step(1'b1, 1'b1);
        end
        check_eq(tag, 32'(found), 32'd1);
    endtask

    task automatic fill_random();
        int op;
        for (int a = 0; a < 1024; a++) begin
            op = ($urandom_range(0, 39) == 0) ? int'($urandom_range(7, 15)) : int'($urandom_range(0, 6));
            imem[a] = {4'(op), 12'($urandom)};
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        m_pc      = 0;
        m_halt    = 1'b0;
        rst       = 1'b0;
        en        = 1'b0;
        rf_a_zero = 1'b0;
        imem_rdata = 16'h0000;
        fill_random();

        // Directed program: all opcodes, taken/untaken/backward/self-loop JMPZ, halt.
        imem[0] = 16'h3105;  // LOADC r1, 0x05
        imem[1] = 16'h0005;  // LOAD  r0, [5]
        imem[2] = 16'h1009;  // STORE r0, [9]
        imem[3] = 16'h5002;  // JMPZ  r0, +2
        imem[4] = 16'h52FF;  // JMPZ  r2, -1
        imem[5] = 16'h2012;  // ADD   r0 = r1 + r2
        imem[6] = 16'h4021;  // SUBS  r0 = r2 - r1
        imem[7] = 16'h6100;  // ABS   r1 = |r1|
        imem[8] = 16'h5000;  // JMPZ  r0, 0 (self loop)
        imem[9] = 16'hFFFF;  // illegal
        zero_plan = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 80; i++) step(1'b1, 1'b1);

        // Stall in the MEM cycle of a STORE, then resume.
        imem[0] = 16'h1009;
        imem[1] = 16'h3105;
        imem[2] = 16'hF000;
        do_reset();
        run_to_store("stall_reach_store");
        repeat (3) step(1'b0, 1'b1);
        repeat (8) step(1'b1, 1'b1);

        // Reset during the MEM cycle of a STORE.
        do_reset();
        run_to_store("rst_reach_store");
        step(1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b1);

        // Branch wrap below zero, then pc increment wrap from 1023 to 0.
        imem[0]    = 16'h50FF;
        imem[1023] = 16'hF000;
        zero_plan  = '{1'b1};
        do_reset();
        repeat (12) step(1'b1, 1'b1);

        // Random programs with random stalls and resets.
        fill_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (m_halt && $urandom_range(0, 7) == 0) begin
                fill_random();
                step(1'b1, 1'b0);
            end else if ($urandom_range(0, 249) == 0) begin
                step(1'b1, 1'b0);
            end else begin
                step(1'($urandom_range(0, 4) != 0), 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
